// File: rtl/fsm_stream_pkg.sv
// rtl/fsm_stream_pkg.sv - shared types and code constants for the detector stream controller
package fsm_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } ctrl_state_t;

  typedef logic [1:0] fsm_code_t;

  localparam fsm_code_t CODE_0 = 2'd0;
  localparam fsm_code_t CODE_1 = 2'd1;
  localparam fsm_code_t CODE_2 = 2'd2;
  localparam fsm_code_t CODE_3 = 2'd3;

endpackage

// File: rtl/fsm_stream_ctrl_piso_shifter.sv
// rtl/fsm_stream_ctrl_piso_shifter.sv - parallel-load shift-left register with last-bit down-counter
module piso_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             msb_o,
  output logic             next_o,
  output logic             last_o
);

  localparam int BW = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bitcnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sreg   <= '0;
      bitcnt <= '0;
    end else if (load_i) begin
      sreg   <= data_i;
      bitcnt <= BW'(WIDTH - 1);
    end else if (shift_i) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
      if (bitcnt != '0) bitcnt <= bitcnt - 1'b1;
    end
  end

  // next_o is the bit that becomes the MSB after the coming shift
  assign msb_o  = sreg[WIDTH-1];
  assign next_o = sreg[WIDTH-2];
  assign last_o = (bitcnt == '0);

endmodule

// File: rtl/fsm_stream_ctrl.sv
// rtl/fsm_stream_ctrl.sv - feeds a word MSB-first into a serial detector and counts matching output codes
module fsm_stream_ctrl
  import fsm_stream_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CLEAR_EN = 1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       match_i,
  output logic             fsm_reset_o,
  output logic             fsm_in_o,
  input  logic [1:0]       fsm_out_i,
  output logic [CW-1:0]    count_o,
  output logic             done_o
);

  ctrl_state_t state;
  fsm_code_t   match_q;
  logic [CW-1:0] count;
  logic        accept;
  logic        hit;
  logic        sh_msb;
  logic        sh_next;
  logic        sh_last;

  assign ready_o     = (state == IDLE) && !reset_i;
  assign fsm_reset_o = reset_i || (state == CLEAR);
  assign accept      = valid_i && ready_o;
  assign hit         = (fsm_out_i == match_q);

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (accept),
    .data_i  (data_i),
    .shift_i (state == SHIFT),
    .msb_o   (sh_msb),
    .next_o  (sh_next),
    .last_o  (sh_last)
  );

  // fsm_in_o is registered one step ahead so the detector sees a flop output
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      match_q  <= CODE_0;
      count    <= '0;
      count_o  <= '0;
      done_o   <= 1'b0;
      fsm_in_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            match_q <= match_i;
            count   <= '0;
            if (CLEAR_EN != 0) begin
              state    <= CLEAR;
              fsm_in_o <= 1'b0;
            end else begin
              state    <= SHIFT;
              fsm_in_o <= data_i[WIDTH-1];
            end
          end
        end
        CLEAR: begin
          state    <= SHIFT;
          fsm_in_o <= sh_msb;
        end
        SHIFT: begin
          if (sh_last) begin
            state    <= REPORT;
            count_o  <= count + CW'(hit);
            done_o   <= 1'b1;
            fsm_in_o <= 1'b0;
          end else begin
            count    <= count + CW'(hit);
            fsm_in_o <= sh_next;
          end
        end
        REPORT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_stream_ctrl.sv
// tb/tb_fsm_stream_ctrl.sv - directed bench driving a clearing and a non-clearing controller in parallel
module tb_fsm_stream_ctrl;
  import fsm_stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, valid;
  logic [7:0] data;
  fsm_code_t  match;

  logic       ready1, frst1, fin1, done1;
  logic [3:0] cnt1;
  fsm_code_t  out1;
  logic       ready0, frst0, fin0, done0;
  logic [3:0] cnt0;
  fsm_code_t  out0;

  logic       use_det;
  logic       prev;
  fsm_code_t  det_out;

  int checks = 0;
  int passed = 0;

  fsm_stream_ctrl #(.WIDTH(8), .CLEAR_EN(1)) u1 (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .ready_o(ready1),
    .data_i(data), .match_i(match), .fsm_reset_o(frst1), .fsm_in_o(fin1),
    .fsm_out_i(out1), .count_o(cnt1), .done_o(done1)
  );

  fsm_stream_ctrl #(.WIDTH(8), .CLEAR_EN(0)) u0 (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .ready_o(ready0),
    .data_i(data), .match_i(match), .fsm_reset_o(frst0), .fsm_in_o(fin0),
    .fsm_out_i(out0), .count_o(cnt0), .done_o(done0)
  );

  // small Mealy detector: code 01 on a rising input, 10 on a repeated one
  always_ff @(posedge clk) begin
    if (reset || frst1) prev <= 1'b0;
    else                prev <= fin1;
  end
  assign det_out = {fin1 & prev, fin1 & ~prev};
  assign out1    = use_det ? det_out : {1'b0, fin1};
  assign out0    = {1'b0, fin0};

  function automatic int det_golden(input logic [7:0] d, input fsm_code_t m);
    int n;
    logic p;
    fsm_code_t code;
    n = 0;
    p = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      code = {d[i] & p, d[i] & ~p};
      if (code == m) n++;
      p = d[i];
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    fsm_code_t  match;
    logic       det;
    int         exp1;
    int         exp0;
  } vec_t;

  task automatic run_word(input vec_t v, input string tag);
    logic [7:0] b1, b0;
    int rmask1, r0, dn1, dn0, dc1, dc0, c1, c0;
    b1 = '0; b0 = '0; rmask1 = 0; r0 = 0;
    dn1 = 0; dn0 = 0; dc1 = -1; dc0 = -1; c1 = -1; c0 = -1;
    use_det = v.det;
    @(negedge clk);
    chk({tag, " ready"}, int'({ready1, ready0}), 3);
    valid = 1'b1; data = v.data; match = v.match;
    @(posedge clk);
    #1;
    valid = 1'b0; data = 8'h00; match = CODE_2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (frst1) rmask1 |= (1 << c);
      if (frst0) r0++;
      if (c >= 2 && c <= 9) b1[9-c] = fin1;
      if (c >= 1 && c <= 8) b0[8-c] = fin0;
      if (done1) begin dn1++; dc1 = c; c1 = int'(cnt1); end
      if (done0) begin dn0++; dc0 = c; c0 = int'(cnt0); end
    end
    chk({tag, " u1 done pulses"}, dn1, 1);
    chk({tag, " u1 done cycle"}, dc1, 10);
    chk({tag, " u1 count"}, c1, v.exp1);
    chk({tag, " u1 serial bits"}, int'(b1), int'(v.data));
    chk({tag, " u1 clear cycles"}, rmask1, 2);
    chk({tag, " u0 done pulses"}, dn0, 1);
    chk({tag, " u0 done cycle"}, dc0, 9);
    chk({tag, " u0 count"}, c0, v.exp0);
    chk({tag, " u0 serial bits"}, int'(b0), int'(v.data));
    chk({tag, " u0 clear cycles"}, r0, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int rdy_busy, dn1, dn0;
    int d1c[2], d1v[2], d0c[2], d0v[2];

    vecs[0] = '{8'hB5, CODE_1, 1'b0, 5, 5};
    vecs[1] = '{8'hFF, CODE_1, 1'b0, 8, 8};
    vecs[2] = '{8'hA5, CODE_3, 1'b0, 0, 0};
    vecs[3] = '{8'h00, CODE_0, 1'b0, 8, 8};
    vecs[4] = '{8'hB5, CODE_0, 1'b0, 3, 3};
    vecs[5] = '{8'b01011011, CODE_1, 1'b1, det_golden(8'b01011011, CODE_1), 5};

    reset = 1'b1; valid = 1'b0; data = '0; match = CODE_0; use_det = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", int'({ready1, ready0}), 0);
    chk("reset fsm_reset", int'({frst1, frst0}), 3);
    chk("reset done", int'({done1, done0}), 0);
    chk("reset count", int'({cnt1, cnt0}), 0);
    chk("reset fsm_in", int'({fin1, fin0}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset ready", int'({ready1, ready0}), 3);
    chk("post-reset fsm_reset", int'({frst1, frst0}), 0);

    for (int i = 0; i < 6; i++) run_word(vecs[i], $sformatf("vec%0d", i));

    // valid held high across two words
    use_det = 1'b0;
    rdy_busy = 0; dn1 = 0; dn0 = 0;
    d1c = '{-1, -1}; d1v = '{-1, -1}; d0c = '{-1, -1}; d0v = '{-1, -1};
    @(negedge clk);
    valid = 1'b1; data = 8'h0F; match = CODE_1;
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) data = 8'hF0;
      if (c <= 10 && ready1) rdy_busy++;
      if (c == 11) chk("hold u1 ready after done", int'(ready1), 1);
      if (done1) begin
        if (dn1 < 2) begin d1c[dn1] = c; d1v[dn1] = int'(cnt1); end
        dn1++;
      end
      if (done0) begin
        if (dn0 < 2) begin d0c[dn0] = c; d0v[dn0] = int'(cnt0); end
        dn0++;
      end
      if (c == 12) valid = 1'b0;
    end
    chk("hold u1 ready while busy", rdy_busy, 0);
    chk("hold u1 done count", dn1, 2);
    chk("hold u1 first done", d1c[0], 10);
    chk("hold u1 second done", d1c[1], 21);
    chk("hold u1 counts", d1v[0] * 16 + d1v[1], 4 * 16 + 4);
    chk("hold u0 done count", dn0, 2);
    chk("hold u0 first done", d0c[0], 9);
    chk("hold u0 second done", d0c[1], 19);
    chk("hold u0 counts", d0v[0] * 16 + d0v[1], 4 * 16 + 4);

    // reset in the middle of a word, with valid asserted alongside it
    @(negedge clk);
    valid = 1'b1; data = 8'hB5; match = CODE_1;
    @(posedge clk);
    #1 valid = 1'b0;
    dn1 = 0; dn0 = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (done1) dn1++;
      if (done0) dn0++;
      if (c == 5) begin reset = 1'b1; valid = 1'b1; data = 8'hFF; end
      if (c == 6) begin
        chk("abort fsm_reset", int'({frst1, frst0}), 3);
        chk("abort ready", int'({ready1, ready0}), 0);
        chk("abort count cleared", int'({cnt1, cnt0}), 0);
        chk("abort fsm_in", int'({fin1, fin0}), 0);
      end
      if (c == 7) begin reset = 1'b0; valid = 1'b0; end
      if (c == 8) begin
        chk("abort ready after reset", int'({ready1, ready0}), 3);
        chk("abort fsm_reset after reset", int'({frst1, frst0}), 0);
      end
    end
    chk("abort no done", dn1 + dn0, 0);
    chk("abort count held", int'({cnt1, cnt0}), 0);
    run_word(vecs[0], "after-abort");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
